// File: rtl/imm_pkg.sv
// Shared encodings, buffer depth and buffer entry layout for the immediate generator.
package imm_pkg;

    typedef enum logic [2:0] {
        I_TYPE    = 3'b000,
        S_TYPE    = 3'b001,
        B_TYPE    = 3'b010,
        JALR_TYPE = 3'b011,
        JAL_TYPE  = 3'b100,
        LUI_TYPE  = 3'b101,
        ZIMM_TYPE = 3'b110,
        RSVD_TYPE = 3'b111
    } imm_src_e;

    localparam int BUF_DEPTH = 2;

    // Entry fields are sized for the widest legal configuration; narrower
    // instances zero-extend on write and slice on read.
    localparam int IMM_MAX_W = 64;
    localparam int TAG_MAX_W = 32;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        logic [TAG_MAX_W-1:0] tag;
        logic                 err;
    } imm_entry_t;

endpackage

// File: rtl/imm_extend_comb.sv
// Combinational RISC-V immediate decoder, XLEN-wide, with illegal-format flag.
// Zimm decoding for ImmSrc=110 exists only when IMM_EXTEND_ZIMM_EN is defined.
module imm_extend_comb
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      ImmSrc,
    output logic [XLEN-1:0] imm,
    output logic            err
);

    // Size casts of signed operands sign-extend, which covers every format
    // including U-type on RV64 without zero-width replications at XLEN=32.
    always_comb begin
        imm = XLEN'($signed(instr[31:20]));
        err = 1'b0;
        case (ImmSrc)
            I_TYPE, JALR_TYPE: imm = XLEN'($signed(instr[31:20]));
            S_TYPE:   imm = XLEN'($signed({instr[31:25], instr[11:7]}));
            B_TYPE:   imm = XLEN'($signed({instr[31], instr[7], instr[30:25],
                                           instr[11:8], 1'b0}));
            JAL_TYPE: imm = XLEN'($signed({instr[31], instr[19:12], instr[20],
                                           instr[30:21], 1'b0}));
            LUI_TYPE: imm = XLEN'($signed({instr[31:12], 12'b0}));
`ifdef IMM_EXTEND_ZIMM_EN
            ZIMM_TYPE: imm = XLEN'(instr[19:15]);
`endif
            default:  err = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate generator feeding a 2-entry valid/ready buffer with flush.
// Optional Zimm format is enabled by defining IMM_EXTEND_ZIMM_EN.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmExt,
    output logic [TAG_W-1:0] out_tag,
    output logic             imm_err
);

    logic [XLEN-1:0] new_imm;
    logic            new_err;

    imm_extend_comb #(.XLEN(XLEN)) u_comb (
        .instr  (instr),
        .ImmSrc (ImmSrc),
        .imm    (new_imm),
        .err    (new_err)
    );

    imm_entry_t mem [BUF_DEPTH];
    logic       head;
    logic       tail;
    logic [1:0] count;
    logic       push;
    logic       pop;

    assign in_ready  = (count < 2'(BUF_DEPTH));
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (push) begin
                mem[tail] <= '{imm: IMM_MAX_W'(new_imm),
                               tag: TAG_MAX_W'(in_tag),
                               err: new_err};
                tail      <= ~tail;
            end
            if (pop) head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Outputs read zero whenever the buffer is empty, so stale data never leaks.
    assign ImmExt  = out_valid ? mem[head].imm[XLEN-1:0]  : '0;
    assign out_tag = out_valid ? mem[head].tag[TAG_W-1:0] : '0;
    assign imm_err = out_valid & mem[head].err;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: XLEN=32 and XLEN=64 instances against a queue model.
module tb_imm_extend_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  src;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, err32;
    logic [31:0] imm32;
    logic [7:0]  tag32;
    logic        in_ready64, out_valid64, err64;
    logic [63:0] imm64;
    logic [7:0]  tag64;

    int total = 0;
    int bad   = 0;

    imm_extend_pipe #(.XLEN(32), .TAG_W(8)) u32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready32), .instr(instr), .ImmSrc(src), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .ImmExt(imm32),
        .out_tag(tag32), .imm_err(err32)
    );

    imm_extend_pipe #(.XLEN(64), .TAG_W(8)) u64 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready64), .instr(instr), .ImmSrc(src), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .ImmExt(imm64),
        .out_tag(tag64), .imm_err(err64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        err;
    } exp_t;

    exp_t q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference immediate via arithmetic on a sign-extended 64-bit word.
    function automatic exp_t model_entry(input logic [31:0] ins, input logic [2:0] s,
                                         input logic [7:0] tg);
        exp_t   e;
        longint si;
        si    = longint'($signed(ins));
        e.tag = tg;
        e.err = 1'b0;
        case (s)
            3'd0, 3'd3: e.imm = si >>> 20;
            3'd1: e.imm = ((si >>> 25) <<< 5) | longint'(ins[11:7]);
            3'd2: e.imm = ((si >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                        | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
            3'd4: e.imm = ((si >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                        | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
            3'd5: e.imm = (si >>> 12) <<< 12;
`ifdef IMM_EXTEND_ZIMM_EN
            3'd6: e.imm = longint'(ins[19:15]);
`endif
            default: begin
                e.imm = si >>> 20;
                e.err = 1'b1;
            end
        endcase
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit do_push, do_pop;
        if (!rst_n || flush) begin
            q.delete();
        end else begin
            do_push = in_valid && (q.size() < 2);
            do_pop  = (q.size() > 0) && out_ready;
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(model_entry(instr, src, in_tag));
        end
    end

    always @(negedge clk) begin
        bit v;
        v = (q.size() != 0);
        chk("out_valid32", 64'(out_valid32), 64'(v));
        chk("out_valid64", 64'(out_valid64), 64'(v));
        chk("in_ready32", 64'(in_ready32), 64'(q.size() < 2));
        chk("in_ready64", 64'(in_ready64), 64'(q.size() < 2));
        if (v) begin
            chk("imm32", 64'(imm32), 64'(q[0].imm[31:0]));
            chk("imm64", imm64, q[0].imm);
            chk("tag32", 64'(tag32), 64'(q[0].tag));
            chk("tag64", 64'(tag64), 64'(q[0].tag));
            chk("err32", 64'(err32), 64'(q[0].err));
            chk("err64", 64'(err64), 64'(q[0].err));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  s;
        logic [63:0] e64;
        logic        e_err;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{32'hFFF00093, 3'd0, 64'hFFFFFFFF_FFFFFFFF, 1'b0};
        vecs[1] = '{32'hFE112E23, 3'd1, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
        vecs[2] = '{32'hFE000CE3, 3'd2, 64'hFFFFFFFF_FFFFFFF8, 1'b0};
        vecs[3] = '{32'h123450B7, 3'd5, 64'h00000000_12345000, 1'b0};
        vecs[4] = '{32'h800000B7, 3'd5, 64'hFFFFFFFF_80000000, 1'b0};
        vecs[5] = '{32'hFFF00093, 3'd7, 64'hFFFFFFFF_FFFFFFFF, 1'b1};
`ifdef IMM_EXTEND_ZIMM_EN
        vecs[6] = '{32'h000A8073, 3'd6, 64'h00000000_00000015, 1'b0};
`else
        vecs[6] = '{32'h000A8073, 3'd6, 64'h00000000_00000000, 1'b1};
`endif
        vecs[7] = '{32'hFFDFF06F, 3'd4, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
        vecs[8] = '{32'h00C080E7, 3'd3, 64'h00000000_0000000C, 1'b0};
        vecs[9] = '{32'h7FF00093, 3'd0, 64'h00000000_000007FF, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; instr = '0; src = '0;
        in_tag = '0; out_ready = 1'b0;
        step(); step();
        chk("rst_out_valid", 64'(out_valid32), 64'd0);
        chk("rst_in_ready", 64'(in_ready64), 64'd1);
        chk("rst_imm64", imm64, 64'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;

        foreach (vecs[i]) begin
            exp_t m;
            instr = vecs[i].ins; src = vecs[i].s; in_tag = 8'(8'h10 + i);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            m = model_entry(vecs[i].ins, vecs[i].s, 8'h00);
            chk($sformatf("model_vec%0d", i), m.imm, vecs[i].e64);
            chk($sformatf("lit_imm32_v%0d", i), 64'(imm32), 64'(vecs[i].e64[31:0]));
            chk($sformatf("lit_imm64_v%0d", i), imm64, vecs[i].e64);
            chk($sformatf("lit_err_v%0d", i), 64'(err32), 64'(vecs[i].e_err));
            chk($sformatf("lit_valid_v%0d", i), 64'(out_valid64), 64'd1);
            step();
        end

        // back-pressure: three pushes into a stalled 2-entry buffer
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'hFFF00093; src = 3'd0; in_tag = 8'd1;
        step();
        chk("bp_ready_after1", 64'(in_ready32), 64'd1);
        instr = 32'hFE112E23; src = 3'd1; in_tag = 8'd2;
        step();
        chk("bp_ready_after2", 64'(in_ready32), 64'd0);
        instr = 32'h123450B7; src = 3'd5; in_tag = 8'd3;
        step(); step();
        chk("bp_head_tag", 64'(tag32), 64'd1);
        chk("bp_head_imm", 64'(imm32), 64'hFFFFFFFF);
        in_valid = 1'b0;
        step();
        chk("bp_stable_imm", 64'(imm32), 64'hFFFFFFFF);
        out_ready = 1'b1;
        step();
        chk("bp_second_tag", 64'(tag64), 64'd2);
        chk("bp_second_imm", imm64, 64'hFFFFFFFF_FFFFFFFC);
        step();
        chk("bp_drained", 64'(out_valid32), 64'd0);
        chk("bp_ready_back", 64'(in_ready32), 64'd1);

        // flush with a same-cycle push
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'h00100093; src = 3'd0; in_tag = 8'h21;
        step();
        in_tag = 8'h22;
        step();
        flush = 1'b1; in_tag = 8'h77;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_valid", 64'(out_valid32), 64'd0);
        chk("fl_ready", 64'(in_ready64), 64'd1);
        out_ready = 1'b1;
        repeat (3) step();
        chk("fl_never_out", 64'(out_valid64), 64'd0);

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid = 1'b1; instr = 32'hFFF00093; src = 3'd0; in_tag = 8'h31;
        step();
        in_valid = 1'b0;
        chk("ar_valid_pre", 64'(out_valid32), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid32), 64'd0);
        chk("ar_imm32", 64'(imm32), 64'd0);
        chk("ar_imm64", imm64, 64'd0);
        chk("ar_tag", 64'(tag32), 64'd0);
        chk("ar_ready", 64'(in_ready64), 64'd1);
        step();
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Registered, parametrised immediate generator for the decode stage of the pipelined core. Accepts a full 32-bit instruction plus an immediate-format select, and produces an XLEN-wide extended immediate one cycle later through a 2-entry valid/ready output buffer. The buffer decouples decode from execute back-pressure. The block adds XLEN scaling (32/64), an opaque sideband tag, an illegal-format flag and a pipeline flush.

## Interface
- XLEN, 32, output immediate width; legal values 32 or 64.
- TAG_W, 8, sideband tag width (rd index, ROB id, etc.), passed through unchanged.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  discards all buffered entries and any same-cycle input.
- in_valid  in  1  input entry present.
- in_ready  out  1  block can accept; high exactly when buffer count < 2.
- instr  in  32  full instruction word.
- ImmSrc  in  3  format select: 000 I, 001 S, 010 B, 011 Jalr, 100 Jal, 101 Lui/U, 110 Zimm, 111 reserved.
- in_tag  in  TAG_W  sideband.
- out_valid  out  1  head entry valid.
- out_ready  in  1  consumer accepts the head.
- ImmExt  out  XLEN  extended immediate of the head entry.
- out_tag  out  TAG_W  tag of the head entry.
- imm_err  out  1  head entry used an illegal ImmSrc.

## Operation
- Push = in_valid & in_ready & !flush. Pop = out_valid & out_ready & !flush.
- Immediate is computed combinationally from instr/ImmSrc and stored with the tag and the error flag. Sign bit is instr[31]; S = sign bit replicated to XLEN.
- I / Jalr: {S, instr[31:20]}.
- S-format: {S, instr[31:25], instr[11:7]}.
- B-format: {S, instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- Jal: {S, instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- Lui/U: {S, instr[31:12], 12'b0}. For XLEN=64 the upper 32 bits are sign-extended (RV64 semantics).
- Zimm: zero-extended instr[19:15]. Available only when the macro in Configuration is defined.
- Illegal ImmSrc (111, or 110 without the macro): ImmExt computed as I-format and imm_err=1 for that entry. Otherwise imm_err=0.
- Buffer: 2-entry FIFO with head/tail pointers (1 bit each, wrapping) and a count register 0..2.
- Push and pop in the same cycle at count=1: count stays 1, and the head advances to the new entry.
- At count=2 no push occurs, because in_ready=0.
- At count=0 a pop cannot occur.

## Timing
- Latency: an entry pushed in cycle N appears on out_valid/ImmExt in cycle N+1. There is no combinational path from in_* to out_*.
- in_ready depends only on registered count. There is no combinational path from out_ready to in_ready.
- Outputs hold stable while out_valid=1 and out_ready=0.
- flush: on the next edge count→0, pointers→0 and out_valid→0. A same-cycle push is dropped. flush takes priority over push and pop.
- Reset (async, rst_n=0): count=0, pointers=0, out_valid=0, ImmExt=0, out_tag=0, imm_err=0, in_ready=1. Reset mid-operation discards all entries immediately, with no edge required.

## Configuration
- IMM_EXTEND_ZIMM_EN defined: ImmSrc 110 decodes Zimm (CSR immediate) as above, with imm_err=0.
- IMM_EXTEND_ZIMM_EN undefined: 110 is illegal and follows the illegal-format rule. No zimm logic is synthesised.

## Structure
- Shared package imm_pkg holds:
  - ImmSrc encodings: I_TYPE, S_TYPE, B_TYPE, JALR_TYPE, JAL_TYPE, LUI_TYPE, ZIMM_TYPE.
  - The buffer depth constant (2).
  - The buffer entry struct {imm, tag, err}.
- One sub-module, imm_extend_comb: purely combinational, parametrised by XLEN, producing imm and err from instr/ImmSrc. The top level holds the buffer, pointers and count.

## Test plan
- XLEN=32, ImmSrc=000, instr=0xFFF00093 (addi x1,x0,-1) → ImmExt=0xFFFFFFFF one cycle after push, imm_err=0.
- Per-format checks:
  - ImmSrc=001, instr=0xFE112E23 → 0xFFFFFFFC.
  - ImmSrc=010, instr=0xFE000CE3 → 0xFFFFFFF8.
  - ImmSrc=101, instr=0x123450B7 → 0x12345000.
- XLEN=64, ImmSrc=101, instr=0x800000B7 → ImmExt=0xFFFFFFFF80000000.
- Back-pressure: hold out_ready=0 and push three entries with tags 1, 2, 3.
  - in_ready drops after the second push; tag 3 is not accepted.
  - Release out_ready: tags pop in order 1 then 2, ImmExt stays stable while stalled, count returns to 0.
- ImmSrc=111, instr=0xFFF00093 → ImmExt=0xFFFFFFFF, imm_err=1. ImmSrc=110 with instr[19:15]=10101:
  - With IMM_EXTEND_ZIMM_EN: ImmExt=0x15, imm_err=0.
  - Without it: imm_err=1.
- Fill 2 entries, then assert flush together with in_valid → next cycle out_valid=0, in_ready=1, and the flushed-cycle input is never output. Drop rst_n mid-stream → out_valid=0 and ImmExt=0 immediately.
